// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package mux_pkg;

    // Values of the mode input.
    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Ceiling log2, used to size channel-index signals (returns 0 for value <= 1).
    function automatic int mux_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr_i,
// scanning ptr_i+1, ptr_i+2, ... modulo N. Works for any N >= 2, including
// non-powers of two, and never produces an index >= N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [SEL_W-1:0] grant_idx_o,
    output logic             grant_any_o
);

    // Scan from the farthest candidate back to the nearest so the last match
    // written is the first one in round-robin order.
    always_comb begin
        int idx;
        idx         = 0;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (req_i[idx]) begin
                grant_oh_o      = '0;
                grant_oh_o[idx] = 1'b1;
                grant_idx_o     = SEL_W'(idx);
                grant_any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel stream multiplexer with a registered output slot and valid/ready
// flow control. SELECT mode forwards the channel named by sel; ROUND-ROBIN
// mode arbitrates fairly among valid channels using rr_ptr (last granted).
module rr_stream_mux #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int SEL_W = mux_pkg::mux_clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);
    import mux_pkg::*;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic [N-1:0]     sel_oh;
    logic [N-1:0]     rr_oh;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [N-1:0]     grant_oh;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic [W-1:0]     grant_data;
    logic             load;

    // SELECT-mode request: only the addressed channel, and only if it is valid.
    // An out-of-range sel matches no channel, so it yields no grant.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel
            assign sel_oh[gi] = in_valid[gi] && (sel == SEL_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (rr_oh),
        .grant_idx_o (rr_idx),
        .grant_any_o (rr_any)
    );

    assign grant_oh  = (mode == MODE_RR) ? rr_oh  : sel_oh;
    assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
    assign grant_any = (mode == MODE_RR) ? rr_any : (|sel_oh);

    // The output slot can take a new beat when empty or draining this cycle.
    assign load = !out_valid_q || out_ready;

    // Ready is forced low during reset so no beat is accepted and then lost.
    assign in_ready = (load && !rst) ? grant_oh : '0;

    // Data of the granted channel; grant_oh is one-hot or zero.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_oh[i]) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    // Next state of the output slot and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (grant_any) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_sel_d   = grant_idx;
                if (mode == MODE_RR) begin
                    rr_ptr_d = grant_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; rr_ptr resets to N-1 so channel 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= SEL_W'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed scenarios plus randomized traffic checked
// against a transaction-level reference model (N=4 instance), and a N=3
// instance for wrap and out-of-range select behaviour.
module tb_rr_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;

    rr_stream_mux #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    rr_stream_mux #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
        .out_ready(out_ready3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the N=4 instance: the beat in the output slot and
    // the last channel granted in round-robin mode.
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
    int         m_ptr;

    // Channel the rules pick from the current inputs, or -1 for none.
    function automatic int ref_grant(input logic md, input int s, input logic [3:0] v, input int ptr);
        if (md == 1'b0) begin
            if (s < 4) begin
                if (v[s]) return s;
            end
            return -1;
        end
        for (int k = 1; k <= 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] ref_ready();
        int g;
        if (m_valid && !out_ready) return 4'b0000;
        g = ref_grant(mode, int'(sel), in_valid, m_ptr);
        if (g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    task automatic ref_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_ptr   = 3;
    endtask

    // Update the model for the coming edge, then move past that edge.
    task automatic advance();
        int g;
        if (!m_valid || out_ready) begin
            g = ref_grant(mode, int'(sel), in_valid, m_ptr);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*8 +: 8];
                m_sel   = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = 32'h0;
        out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b0; in_data3 = 24'h0; out_ready3 = 1'b1;
        ref_reset();
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_cmp++; if (out_sel !== 2'd0) begin n_bad++; $display("FAIL reset_out_sel: got %0d expected 0", out_sel); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        n_cmp++; if (out_valid3 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid3: got %b expected 0", out_valid3); end
        rst = 1'b0; in_valid = 4'h0;
        #1;
    endtask

    task automatic test_select_pass();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = {8'h44, 8'h05, 8'h22, 8'h11};
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL select_in_ready: got %b expected 0100", in_ready); end
        advance();
        $display("beat ch=%0d data=%h", out_sel, out_data);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL select_out_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_data !== 8'h05) begin n_bad++; $display("FAIL select_out_data: got %h expected 05", out_data); end
        n_cmp++; if (out_sel !== 2'd2) begin n_bad++; $display("FAIL select_out_sel: got %0d expected 2", out_sel); end
    endtask

    task automatic test_select_miss();
        sel = 2'd1; in_valid = 4'b0101;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL miss_in_ready: got %b expected 0000", in_ready); end
        advance();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL miss_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h05) begin n_bad++; $display("FAIL miss_data_hold: got %h expected 05", out_data); end
        n_cmp++; if (out_sel !== 2'd2) begin n_bad++; $display("FAIL miss_sel_hold: got %0d expected 2", out_sel); end
    endtask

    task automatic test_rr_rotation();
        logic [7:0] exp_d;
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = $urandom;
            exp_d = in_data[(k % 4)*8 +: 8];
            #1;
            n_cmp++; if (in_ready !== (4'b0001 << (k % 4))) begin n_bad++; $display("FAIL rr_in_ready[%0d]: got %b expected ch %0d", k, in_ready, k % 4); end
            advance();
            $display("beat ch=%0d data=%h", out_sel, out_data);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_out_valid[%0d]: got %b expected 1", k, out_valid); end
            n_cmp++; if (out_sel !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_out_sel[%0d]: got %0d expected %0d", k, out_sel, k % 4); end
            n_cmp++; if (out_data !== exp_d) begin n_bad++; $display("FAIL rr_out_data[%0d]: got %h expected %h", k, out_data, exp_d); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] held_d;
        held_d = m_data;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            #1;
            n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b expected 0000", k, in_ready); end
            advance();
            n_cmp++; if (out_sel !== 2'd1) begin n_bad++; $display("FAIL stall_out_sel[%0d]: got %0d expected 1", k, out_sel); end
            n_cmp++; if (out_data !== held_d) begin n_bad++; $display("FAIL stall_out_data[%0d]: got %h expected %h", k, out_data, held_d); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid[%0d]: got %b expected 1", k, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL release_in_ready: got %b expected 0100", in_ready); end
        advance();
        $display("beat ch=%0d data=%h", out_sel, out_data);
        n_cmp++; if (out_sel !== 2'd2) begin n_bad++; $display("FAIL release_out_sel: got %0d expected 2", out_sel); end
    endtask

    task automatic test_n3_wrap();
        in_valid = 4'h0;
        mode3 = 1'b1; out_ready3 = 1'b1; in_valid3 = 3'b100; in_data3 = {8'hC2, 8'hB1, 8'hA0};
        #1;
        n_cmp++; if (in_ready3 !== 3'b100) begin n_bad++; $display("FAIL n3_first_ready: got %b expected 100", in_ready3); end
        advance();
        n_cmp++; if (out_sel3 !== 2'd2) begin n_bad++; $display("FAIL n3_first_sel: got %0d expected 2", out_sel3); end
        in_valid3 = 3'b101;
        #1;
        n_cmp++; if (in_ready3 !== 3'b001) begin n_bad++; $display("FAIL n3_wrap_ready: got %b expected 001", in_ready3); end
        advance();
        $display("beat n3 ch=%0d data=%h", out_sel3, out_data3);
        n_cmp++; if (out_sel3 !== 2'd0) begin n_bad++; $display("FAIL n3_wrap_sel: got %0d expected 0", out_sel3); end
        n_cmp++; if (out_data3 !== 8'hA0) begin n_bad++; $display("FAIL n3_wrap_data: got %h expected a0", out_data3); end
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        n_cmp++; if (in_ready3 !== 3'b000) begin n_bad++; $display("FAIL n3_sel3_ready: got %b expected 000", in_ready3); end
        advance();
        n_cmp++; if (out_valid3 !== 1'b0) begin n_bad++; $display("FAIL n3_sel3_valid: got %b expected 0", out_valid3); end
        in_valid3 = 3'b000;
    endtask

    task automatic test_reset_midstream();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = $urandom;
            advance();
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 0000", in_ready); end
        ref_reset();
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 4'b1010; in_data = 32'h8877_6655;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL post_rst_ready: got %b expected 0010", in_ready); end
        advance();
        $display("beat ch=%0d data=%h", out_sel, out_data);
        n_cmp++; if (out_sel !== 2'd1) begin n_bad++; $display("FAIL post_rst_sel: got %0d expected 1", out_sel); end
        n_cmp++; if (out_data !== 8'h66) begin n_bad++; $display("FAIL post_rst_data: got %h expected 66", out_data); end
    endtask

    task automatic test_random();
        logic [3:0] exp_r;
        for (int k = 0; k < 300; k++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r = ref_ready();
            n_cmp++; if (in_ready !== exp_r) begin n_bad++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", k, in_ready, exp_r); end
            advance();
            if (m_valid) $display("beat ch=%0d data=%h", out_sel, out_data);
            n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", k, out_valid, m_valid); end
            n_cmp++; if (out_data !== m_data) begin n_bad++; $display("FAIL rand_out_data[%0d]: got %h expected %h", k, out_data, m_data); end
            n_cmp++; if (out_sel !== 2'(m_sel)) begin n_bad++; $display("FAIL rand_out_sel[%0d]: got %0d expected %0d", k, out_sel, m_sel); end
        end
    endtask

    initial begin
        test_reset();
        test_select_pass();
        test_select_miss();
        test_rr_rotation();
        test_stall();
        test_n3_wrap();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
